led_rate_meter: RTL and testbench
=================================

Name: led_rate_meter

Overview:
- Measures a slow toggling signal, such as an LED clock-divider output, in units of the system clock.
- Reports the period (rising edge to rising edge) and the high time of that signal, one valid pulse per completed period.
- Detects a stalled input.
- Sits beside the LED divider blocks as their self-check/observation end. It feeds a debug register or a test comparator.

Parameters:
- CNT_W, 16, width of the period and high-time counters/outputs.
- TIMEOUT, 1000, clk cycles without a detected rising edge before the input is declared stalled (2 ≤ TIMEOUT ≤ 2^CNT_W−1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable; 0 forces IDLE, with counters held at 0.
- sig_in  input  1  measured signal; asynchronous to clk.
- period  output  CNT_W  last measured period in clk cycles.
- high_time  output  CNT_W  clk cycles sig was high in that period.
- period_valid  output  1  one-cycle pulse when period/high_time update.
- stalled  output  1  level; sig_in had no rising edge for TIMEOUT cycles.

Behaviour:
- Reset (rst=0, async): period=0, high_time=0, period_valid=0, stalled=0, synchronizer flops=0, state=IDLE, cnt=0, hi_lat=0.
- Input conditioning:
  - 2-flop synchronizer s1→s2, plus a prev register.
  - rise = s2 & ~prev; fall = ~s2 & prev.
  - Detection latency: 3 clk edges from the sig_in transition.
- States:
  - IDLE: cnt=0. On rise with en=1 → MEASURE, cnt←1.
  - MEASURE: cnt increments by 1 each cycle.
    - On fall: hi_lat←cnt.
    - On rise: period←cnt, high_time←hi_lat, period_valid=1 for one cycle (the cycle after the rise is sampled), cnt←1, remain MEASURE.
    - Result: a signal with rising edges N cycles apart yields period=N. High for H cycles yields high_time=H.
  - Timeout: in MEASURE, if cnt==TIMEOUT and no rise that cycle → IDLE, stalled←1, no valid pulse. period/high_time keep their old values.
- stalled clears on the first rise detected in IDLE. It also clears when en=0.
- en=0:
  - State→IDLE, cnt=0, hi_lat=0, period_valid=0.
  - period/high_time hold their last values.
  - Edges seen while en=0 are ignored.
  - The prev register still tracks s2, so no false edge occurs when en returns to 1.
- First period after IDLE:
  - No valid pulse on the entering rise.
  - The first valid pulse comes on the second rise.
  - If no fall occurred in the period (degenerate input), high_time reports 0. hi_lat clears at each rise.
- rise and cnt==TIMEOUT in the same cycle: rise wins (valid measurement, period=TIMEOUT).
- Counter arithmetic is unsigned; cnt never exceeds TIMEOUT, so no wrap.
- Reset mid-measurement: immediate return to reset values; the partial period is discarded.

Optional Feature:
- Macro LED_RATE_METER_AVG_EN.
- When defined:
  - An extra output period_avg [CNT_W-1:0] reports the mean of the last 4 valid periods, computed as (sum of 4)>>2 with CNT_W+2-bit sum, truncated.
  - It updates in the same cycle as period_valid.
  - Before 4 samples exist, missing entries count as 0.
  - History clears on reset, stall, or en=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset held, random sig_in → all outputs 0; after release with en=0, sig_in toggling → period_valid never asserts.
- en=1, square wave period 10 (high 4, low 6) for 5 periods → first valid on 2nd rise (+3 cycles latency), then every 10 cycles, period=10, high_time=4.
- Change wave to period 37/high 20 mid-stream → next valid reports 37/20 exactly one period later; no spurious intermediate values.
- sig_in held high after measuring period 10 → stalled=1 exactly TIMEOUT=1000 cycles after the last rise count start; period stays 10; next rise clears stalled, and the following rise gives a valid pulse.
- Period exactly TIMEOUT (1000) → valid with period=1000, stalled stays 0; period 1001 → stall.
- With LED_RATE_METER_AVG_EN, periods 8, 12, 10, 10 → period_avg = 2, 5, 7, 10 on successive valids; then drop rst mid-period → all cleared asynchronously.

Source files
------------

// File: rtl/led_rate_meter.sv
// Period / high-time meter for a slow toggling input, measured in clk cycles, with stall detection.
// Optional LED_RATE_METER_AVG_EN adds period_avg, the mean of the last four valid periods.
module led_rate_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             stalled
`ifdef LED_RATE_METER_AVG_EN
  ,
  output logic [CNT_W-1:0] period_avg
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_lat;
  logic             s1, s2, prev;
  logic             rise, fall;
  logic             take_sample, stall_evt;

  // prev keeps tracking s2 even while disabled, so re-enabling never fakes an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise        = s2 & ~prev;
  assign fall        = ~s2 & prev;
  assign take_sample = en && (state == MEASURE) && rise;
  assign stall_evt   = en && (state == MEASURE) && !rise && (cnt == TIMEOUT_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_lat       <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        cnt     <= '0;
        hi_lat  <= '0;
        stalled <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt    <= '0;
            hi_lat <= '0;
            if (rise) begin
              state   <= MEASURE;
              cnt     <= ONE_C;
              stalled <= 1'b0;
            end
          end
          MEASURE: begin
            if (take_sample) begin
              // a rise coinciding with cnt==TIMEOUT is still a valid measurement
              period       <= cnt;
              high_time    <= hi_lat;
              period_valid <= 1'b1;
              cnt          <= ONE_C;
              hi_lat       <= '0;
            end else if (stall_evt) begin
              state   <= IDLE;
              cnt     <= '0;
              hi_lat  <= '0;
              stalled <= 1'b1;
            end else begin
              cnt <= cnt + ONE_C;
              if (fall) begin
                hi_lat <= cnt;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LED_RATE_METER_AVG_EN
  logic [CNT_W-1:0] hist [3];
  logic [CNT_W+1:0] avg_sum;

  // newest sample is the period being reported this cycle; the oldest falls out
  assign avg_sum = (CNT_W+2)'(cnt) + (CNT_W+2)'(hist[0]) +
                   (CNT_W+2)'(hist[1]) + (CNT_W+2)'(hist[2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        hist[i] <= '0;
      end
      period_avg <= '0;
    end else if (!en || stall_evt) begin
      for (int i = 0; i < 3; i++) begin
        hist[i] <= '0;
      end
    end else if (take_sample) begin
      hist[0]    <= cnt;
      hist[1]    <= hist[0];
      hist[2]    <= hist[1];
      period_avg <= avg_sum[CNT_W+1:2];
    end
  end
`endif

endmodule

// File: tb/tb_led_rate_meter.sv
// Directed bench for led_rate_meter: an edge-timestamp model checked every cycle plus literal spot checks.
module tb_led_rate_meter;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             stalled;
`ifdef LED_RATE_METER_AVG_EN
  logic [CNT_W-1:0] period_avg;
`endif

  led_rate_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .stalled      (stalled)
`ifdef LED_RATE_METER_AVG_EN
    ,
    .period_avg   (period_avg)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: sig_in samples per clock edge; an edge is seen 3 edges after it is sampled.
  // Period = distance between seen rises, high time = seen fall minus seen rise.
  int  ecount = 0;
  bit  h [4];
  bit  meas;
  bit  fall_seen;
  bit  rise_m, fall_m;
  int  last_rise, fall_edge, elapsed;
  int  exp_period, exp_high, exp_avg;
  bit  exp_valid, exp_stalled;
  int  hist_q [$];
  int  valid_cnt = 0;
  int  obs_avg [$];

  always @(posedge clk) begin
    ecount++;
    if (!rst) begin
      for (int i = 0; i < 4; i++) h[i] = 1'b0;
      meas = 0; fall_seen = 0;
      exp_period = 0; exp_high = 0; exp_avg = 0;
      exp_valid = 0; exp_stalled = 0;
      hist_q.delete();
    end else begin
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = sig_in;
      rise_m = h[2] && !h[3];
      fall_m = !h[2] && h[3];
      exp_valid = 0;
      if (!en) begin
        meas = 0; exp_stalled = 0;
        hist_q.delete();
      end else if (!meas) begin
        if (rise_m) begin
          meas = 1; last_rise = ecount; fall_seen = 0; exp_stalled = 0;
        end
      end else begin
        elapsed = ecount - last_rise;
        if (rise_m) begin
          exp_period = elapsed;
          exp_high   = fall_seen ? (fall_edge - last_rise) : 0;
          exp_valid  = 1;
          hist_q.push_back(elapsed);
          if (hist_q.size() > 4) void'(hist_q.pop_front());
          exp_avg = 0;
          foreach (hist_q[k]) exp_avg += hist_q[k];
          exp_avg = exp_avg / 4;
          last_rise = ecount; fall_seen = 0;
        end else if (elapsed == TIMEOUT) begin
          meas = 0; exp_stalled = 1;
          hist_q.delete();
        end else if (fall_m) begin
          fall_seen = 1; fall_edge = ecount;
        end
      end
    end
    #2;
    chk("period", int'(period), exp_period);
    chk("high_time", int'(high_time), exp_high);
    chk("period_valid", int'(period_valid), int'(exp_valid));
    chk("stalled", int'(stalled), int'(exp_stalled));
`ifdef LED_RATE_METER_AVG_EN
    chk("period_avg", int'(period_avg), exp_avg);
`endif
    if (period_valid) begin
      valid_cnt++;
`ifdef LED_RATE_METER_AVG_EN
      obs_avg.push_back(int'(period_avg));
      $display("valid t=%0t period=%0d high_time=%0d period_avg=%0d", $time, period, high_time, period_avg);
`else
      $display("valid t=%0t period=%0d high_time=%0d", $time, period, high_time);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1; cyc(hi);
      sig_in = 1'b0; cyc(per - hi);
    end
  endtask

  int v0;

  initial begin
    // reset held with random input
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sig_in = 1'($urandom_range(0, 1));
    end
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    chk("rst_stalled", int'(stalled), 0);
    @(negedge clk);
    rst = 1'b1; sig_in = 1'b0;

    // disabled: toggling must not produce results
    v0 = valid_cnt;
    wave(10, 4, 4);
    chk("en0_valids", valid_cnt - v0, 0);

    // square wave 10/4: five rises, four results
    cyc(5);
    en = 1'b1;
    v0 = valid_cnt;
    wave(10, 4, 5);
    cyc(4);
    chk("sq10_valids", valid_cnt - v0, 4);
    chk("sq10_period", int'(period), 10);
    chk("sq10_high", int'(high_time), 4);

    // switch to 37/20
    wave(37, 20, 3);
    chk("sq37_period", int'(period), 37);
    chk("sq37_high", int'(high_time), 20);

    // stall with input held high
    wave(10, 4, 2);
    sig_in = 1'b1;
    cyc(1100);
    chk("stall_flag", int'(stalled), 1);
    chk("stall_period", int'(period), 10);
    sig_in = 1'b0; cyc(5);
    sig_in = 1'b1; cyc(6);
    chk("stall_cleared", int'(stalled), 0);
    sig_in = 1'b0; cyc(4);
    v0 = valid_cnt;
    wave(10, 4, 2);
    cyc(4);
    chk("post_stall_valids", valid_cnt - v0, 2);

    // period exactly TIMEOUT is valid, TIMEOUT+1 stalls
    wave(1000, 500, 3);
    chk("p1000_period", int'(period), 1000);
    chk("p1000_stalled", int'(stalled), 0);
    wave(1001, 500, 2);
    cyc(10);
    chk("p1001_stalled", int'(stalled), 1);
    chk("p1001_period", int'(period), 1000);

    // averaging sequence 8, 12, 10, 10
    en = 1'b0; cyc(3);
    chk("en0_clears_stall", int'(stalled), 0);
    obs_avg.delete();
    en = 1'b1;
    wave(8, 4, 1);
    wave(12, 6, 1);
    wave(10, 5, 3);
    cyc(4);
    chk("avg_seq_period", int'(period), 10);
`ifdef LED_RATE_METER_AVG_EN
    chk("avg_count", obs_avg.size(), 4);
    if (obs_avg.size() == 4) begin
      chk("avg_1", obs_avg[0], 2);
      chk("avg_2", obs_avg[1], 5);
      chk("avg_3", obs_avg[2], 7);
      chk("avg_4", obs_avg[3], 10);
    end
`endif

    // asynchronous reset mid-period
    sig_in = 1'b1; cyc(3);
    #3 rst = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_high", int'(high_time), 0);
    chk("arst_valid", int'(period_valid), 0);
    chk("arst_stalled", int'(stalled), 0);
`ifdef LED_RATE_METER_AVG_EN
    chk("arst_avg", int'(period_avg), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
